pe_bfu: RTL and testbench
=========================

# pe_bfu

Parametrised, fully pipelined butterfly unit for the NTT datapath, generalising the fixed-mode PE0 butterfly. It accepts one (u, v, w) triple per cycle and supports Cooley-Tukey (forward NTT) and Gentleman-Sande (inverse NTT) butterflies, selected per sample. It provides optional per-sample halving for inverse-transform scaling and valid tracking through the pipeline. It sits between the coefficient memory read ports and the write-back path, one instance per butterfly lane.

## Interface
- DW, 12, coefficient width
- Q, 3329, modulus; Q < 2^DW, Q odd
- MUL_LAT, 4, latency of the modular multiplier in cycles (≥1)
- TW_CONST, 2285, twiddle substituted when tw_sel=0
- clk  in  1  clock; everything rising-edge
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  sample present on u/v/w/mode/tw_sel/half this cycle
- mode  in  1  0 = CT, 1 = GS
- tw_sel  in  1  0 = use TW_CONST, 1 = use w
- half  in  1  1 = halve both results mod Q (meaningful in GS only; ignored in CT)
- u, v, w  in  DW  operands, each in [0, Q)
- out_valid  out  1  bf_a/bf_b carry a new result this cycle
- bf_a, bf_b  out  DW  butterfly results, always in [0, Q)

## Operation
- Let t = tw_sel ? w : TW_CONST. All arithmetic is mod Q, and results are fully reduced.
- CT: bf_a = u + v·t, bf_b = u − v·t.
- GS, half=0: bf_a = u + v, bf_b = (u − v)·t.
- GS, half=1: both GS results are passed through halving: h(x) = x even ? x>>1 : (x+Q)>>1.
- Pipeline:
  - Stage 0: register all inputs, including mode, tw_sel, half and in_valid.
  - Multiplier input: operand A = mode ? (u−v) : v, operand B = t.
  - Multiplier result: A·B mod Q after MUL_LAT cycles.
  - Side path: the non-multiplied term (u in CT, u+v in GS) is delayed MUL_LAT cycles in parallel with the multiplier.
  - Final stage: add/sub (CT) or pass-through (GS), then optional halving, then the output register.
- Control: mode, half and valid travel in the same delay line as the data. Mixed modes back-to-back are legal without bubbles.
- Output register: loads only when the final-stage valid bit is 1; otherwise bf_a/bf_b hold their last value.
- No backpressure: the consumer must accept every out_valid cycle.

## Timing
- Latency is LAT = MUL_LAT + 2 cycles, identical in both modes. A sample with in_valid high at cycle n appears with out_valid high at cycle n+LAT.
- Throughput is 1 sample/cycle. out_valid is exactly in_valid delayed by LAT.
- Reset values: out_valid=0, bf_a=0, bf_b=0, and all valid/mode/half pipeline bits 0.
- Data delay-line contents are don't-care after reset.
- Reset mid-stream: every in-flight sample is discarded. out_valid stays 0 until LAT cycles after the first post-reset in_valid. in_valid asserted during the reset cycle is ignored.
- Boundaries:
  - Sums ≥ Q wrap by subtracting Q.
  - Negative differences wrap by adding Q.
  - u=v gives a difference of 0.
  - v=0 or t=0 gives product 0.
- Inputs ≥ Q are illegal; behaviour is undefined and the bench must not drive them.

## Structure
- Shared package ntt_pkg: Q, DW, TW_CONST, MUL_LAT defaults, and the mode constants BF_CT=0, BF_GS=1.
- Reuse the existing modular_mul, modular_add and modular_substraction.
  - The multiplier must be configured/wrapped to give a plain A·B mod Q in MUL_LAT cycles.
- New sub-module mod_half: combinational halving mod Q, DW wide, instantiated twice.
- Delay lines use a generic shift register parametrised by width and depth (depth MUL_LAT). Data and control use separate instances so control can be reset and data need not be.

## Test plan
Defaults throughout (Q=3329, MUL_LAT=4, LAT=6).
- CT u=5, v=3, w=7, tw_sel=1 → after 6 cycles: bf_a=26, bf_b=3313, out_valid high for exactly 1 cycle.
- CT wrap: u=3328, v=1, w=1 → bf_a=0, bf_b=3327. With tw_sel=0, u=0, v=1 → bf_a=2285, bf_b=1044.
- GS u=10, v=4, w=3: half=0 → bf_a=14, bf_b=18; half=1 → bf_a=7, bf_b=9. Odd case u=4, v=1, w=1, half=1 → bf_a=1667, bf_b=1666.
- Stream of 16 back-to-back samples alternating CT/GS with random legal operands → 16 consecutive out_valid cycles starting at cycle 6, matching a reference model in order. Insert bubbles (in_valid gaps) and verify that outputs hold between valid cycles.
- Assert rst for 1 cycle while 3 samples are in flight → out_valid=0 and bf_a=bf_b=0 next cycle. None of the 3 ever emerge. A new sample 2 cycles later emerges exactly 6 cycles after its input.
- Randomised 10k samples (all mode/tw_sel/half combinations) against the model; additionally check bf_a, bf_b < Q on every out_valid.

Source files
------------

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT datapath constants and butterfly mode encodings
package ntt_pkg;

  localparam int DW       = 12;
  localparam int Q        = 3329;
  localparam int MUL_LAT  = 4;
  localparam int TW_CONST = 2285;

  localparam logic BF_CT = 1'b0;
  localparam logic BF_GS = 1'b1;

endpackage

// File: rtl/mod_half.sv
// rtl/mod_half.sv - combinational x/2 mod Q for odd Q
module mod_half #(
  parameter int DW = ntt_pkg::DW,
  parameter int Q  = ntt_pkg::Q
) (
  input  logic [DW-1:0] a_i,
  output logic [DW-1:0] h_o
);

  logic [DW:0] ext;

  // Odd values become even by adding the odd modulus, then shift right.
  always_comb begin
    ext = a_i[0] ? ({1'b0, a_i} + (DW+1)'(Q)) : {1'b0, a_i};
    h_o = ext[DW:1];
  end

endmodule

// File: rtl/modular_add.sv
// rtl/modular_add.sv - combinational (a + b) mod Q for operands in [0, Q)
module modular_add #(
  parameter int DW = ntt_pkg::DW,
  parameter int Q  = ntt_pkg::Q
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] s_o
);

  logic [DW:0] sum;

  // One conditional subtract suffices since a + b < 2Q.
  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    s_o = (sum >= (DW+1)'(Q)) ? DW'(sum - (DW+1)'(Q)) : DW'(sum);
  end

endmodule

// File: rtl/modular_mul.sv
// rtl/modular_mul.sv - pipelined a*b mod Q (Barrett reduction), LAT cycles
module modular_mul #(
  parameter int DW  = ntt_pkg::DW,
  parameter int Q   = ntt_pkg::Q,
  parameter int LAT = ntt_pkg::MUL_LAT
) (
  input  logic          clk,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] p_o
);

  localparam int PW = 2 * DW;
  localparam int MW = PW + 1;
  // floor(2^PW / Q): never overestimates the quotient, and since p < 2^PW the
  // estimate is short by at most one, leaving r < 2Q.
  localparam longint unsigned BAR_M = (64'd1 << PW) / 64'(Q);

  logic [PW-1:0]    prod;
  logic [PW+MW-1:0] prod_m;
  logic [PW-1:0]    q_est;
  logic [PW-1:0]    r_wide;
  logic [DW:0]      r_nar;
  logic [DW-1:0]    red;

  if (LAT == 1) begin : g_comb_prod
    assign prod = PW'(a_i) * PW'(b_i);
  end else begin : g_reg_prod
    logic [PW-1:0] prod_q;
    // First pipeline stage holds the raw product.
    always_ff @(posedge clk) prod_q <= PW'(a_i) * PW'(b_i);
    assign prod = prod_q;
  end

  // Barrett quotient estimate and single correction step.
  always_comb begin
    prod_m = (PW+MW)'(prod) * (PW+MW)'(BAR_M[MW-1:0]);
    q_est  = PW'(prod_m >> PW);
    r_wide = prod - q_est * PW'(Q);
    r_nar  = (DW+1)'(r_wide);
    red    = (r_nar >= (DW+1)'(Q)) ? DW'(r_nar - (DW+1)'(Q)) : DW'(r_nar);
  end

  shift_reg #(
    .W        (DW),
    .DEPTH    ((LAT > 1) ? LAT - 1 : 1),
    .HAS_RESET(1'b0)
  ) u_red_dly (
    .clk(clk),
    .rst(1'b0),
    .d_i(red),
    .q_o(p_o)
  );

endmodule

// File: rtl/modular_substraction.sv
// rtl/modular_substraction.sv - combinational (a - b) mod Q for operands in [0, Q)
module modular_substraction #(
  parameter int DW = ntt_pkg::DW,
  parameter int Q  = ntt_pkg::Q
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] d_o
);

  logic [DW:0] diff;

  // A borrow into the extra bit marks a negative difference; add Q back.
  always_comb begin
    diff = {1'b0, a_i} - {1'b0, b_i};
    d_o  = diff[DW] ? DW'(diff + (DW+1)'(Q)) : DW'(diff);
  end

endmodule

// File: rtl/shift_reg.sv
// rtl/shift_reg.sv - generic width x depth delay line, reset optional
module shift_reg #(
  parameter int W         = 1,
  parameter int DEPTH     = 1,
  parameter bit HAS_RESET = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q [DEPTH];

  // Shift one slot per cycle; control lines clear on reset, data lines never do.
  always_ff @(posedge clk) begin
    if (HAS_RESET && rst) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/pe_bfu.sv
// rtl/pe_bfu.sv - pipelined CT/GS butterfly unit with optional halving
module pe_bfu #(
  parameter int DW       = ntt_pkg::DW,
  parameter int Q        = ntt_pkg::Q,
  parameter int MUL_LAT  = ntt_pkg::MUL_LAT,
  parameter int TW_CONST = ntt_pkg::TW_CONST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          mode,
  input  logic          tw_sel,
  input  logic          half,
  input  logic [DW-1:0] u,
  input  logic [DW-1:0] v,
  input  logic [DW-1:0] w,
  output logic          out_valid,
  output logic [DW-1:0] bf_a,
  output logic [DW-1:0] bf_b
);

  logic [DW-1:0] u_q, v_q, w_q;
  logic          tw_sel_q;
  logic          valid_q, mode_q, half_q;

  logic [DW-1:0] tw, sum0, diff0, mul_a, side0;
  logic [DW-1:0] prod, side_f;
  logic          valid_f, mode_f, half_f;
  logic [DW-1:0] ct_a, ct_b, gs_ha, gs_hb;
  logic [DW-1:0] bf_a_d, bf_b_d;
  logic [DW-1:0] bf_a_q, bf_b_q;
  logic          out_valid_q;

  // Stage 0 data capture; operand values need no reset.
  always_ff @(posedge clk) begin
    u_q      <= u;
    v_q      <= v;
    w_q      <= w;
    tw_sel_q <= tw_sel;
  end

  // Stage 0 control capture; a sample presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      half_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      mode_q  <= mode;
      half_q  <= half;
    end
  end

  assign tw = tw_sel_q ? w_q : DW'(TW_CONST);

  modular_add #(.DW(DW), .Q(Q)) u_add_in (.a_i(u_q), .b_i(v_q), .s_o(sum0));
  modular_substraction #(.DW(DW), .Q(Q)) u_sub_in (.a_i(u_q), .b_i(v_q), .d_o(diff0));

  // GS multiplies the difference and carries the sum; CT multiplies v and carries u.
  assign mul_a = (mode_q == ntt_pkg::BF_GS) ? diff0 : v_q;
  assign side0 = (mode_q == ntt_pkg::BF_GS) ? sum0  : u_q;

  modular_mul #(.DW(DW), .Q(Q), .LAT(MUL_LAT)) u_mul (
    .clk(clk),
    .a_i(mul_a),
    .b_i(tw),
    .p_o(prod)
  );

  shift_reg #(.W(DW), .DEPTH(MUL_LAT), .HAS_RESET(1'b0)) u_side_dly (
    .clk(clk),
    .rst(rst),
    .d_i(side0),
    .q_o(side_f)
  );

  shift_reg #(.W(3), .DEPTH(MUL_LAT), .HAS_RESET(1'b1)) u_ctl_dly (
    .clk(clk),
    .rst(rst),
    .d_i({valid_q, mode_q, half_q}),
    .q_o({valid_f, mode_f, half_f})
  );

  modular_add #(.DW(DW), .Q(Q)) u_add_out (.a_i(side_f), .b_i(prod), .s_o(ct_a));
  modular_substraction #(.DW(DW), .Q(Q)) u_sub_out (.a_i(side_f), .b_i(prod), .d_o(ct_b));
  mod_half #(.DW(DW), .Q(Q)) u_half_a (.a_i(side_f), .h_o(gs_ha));
  mod_half #(.DW(DW), .Q(Q)) u_half_b (.a_i(prod),   .h_o(gs_hb));

  // Final-stage result select: CT add/sub, GS pass-through, optionally halved.
  always_comb begin
    bf_a_d = ct_a;
    bf_b_d = ct_b;
    if (mode_f == ntt_pkg::BF_GS) begin
      if (half_f) begin
        bf_a_d = gs_ha;
        bf_b_d = gs_hb;
      end else begin
        bf_a_d = side_f;
        bf_b_d = prod;
      end
    end
  end

  // Output register loads only on a valid final-stage sample, else holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bf_a_q      <= '0;
      bf_b_q      <= '0;
    end else begin
      out_valid_q <= valid_f;
      if (valid_f) begin
        bf_a_q <= bf_a_d;
        bf_b_q <= bf_b_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign bf_a      = bf_a_q;
  assign bf_b      = bf_b_q;

endmodule

// File: tb/tb_pe_bfu.sv
// tb/tb_pe_bfu.sv - scoreboard bench for pe_bfu
module tb_pe_bfu;

  localparam int DW  = 12;
  localparam int QM  = 3329;
  localparam int TWC = 2285;
  localparam int LAT = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          mode = 1'b0;
  logic          tw_sel = 1'b0;
  logic          half = 1'b0;
  logic [DW-1:0] u = '0;
  logic [DW-1:0] v = '0;
  logic [DW-1:0] w = '0;
  logic          out_valid;
  logic [DW-1:0] bf_a, bf_b;

  pe_bfu #(.DW(DW), .Q(QM), .MUL_LAT(4), .TW_CONST(TWC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .tw_sel(tw_sel),
    .half(half), .u(u), .v(v), .w(w), .out_valid(out_valid), .bf_a(bf_a), .bf_b(bf_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int a;
    int b;
    int at;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   nvec = 0;
  int   nfail = 0;
  bit   mon_en = 1'b0;
  int   last_a = 0;
  int   last_b = 0;

  // Monitor: pops an expectation on every out_valid, checks hold otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        nvec++;
        if (sbq.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_out cyc=%0d got a=%0d b=%0d, required no out_valid", cyc, bf_a, bf_b);
        end else begin
          e = sbq.pop_front();
          if (cyc != e.at || bf_a !== 12'(e.a) || bf_b !== 12'(e.b)) begin
            nfail++;
            $display("FAIL result cyc=%0d a=%0d b=%0d, required cyc=%0d a=%0d b=%0d",
                     cyc, bf_a, bf_b, e.at, e.a, e.b);
          end
          last_a = e.a;
          last_b = e.b;
        end
        nvec++;
        if (!(bf_a < 12'(QM) && bf_b < 12'(QM))) begin
          nfail++;
          $display("FAIL range cyc=%0d a=%0d b=%0d, required both < %0d", cyc, bf_a, bf_b, QM);
        end
      end else begin
        nvec++;
        if (out_valid !== 1'b0 || bf_a !== 12'(last_a) || bf_b !== 12'(last_b)) begin
          nfail++;
          $display("FAIL hold cyc=%0d valid=%b a=%0d b=%0d, required valid=0 a=%0d b=%0d",
                   cyc, out_valid, bf_a, bf_b, last_a, last_b);
        end
        if (sbq.size() > 0 && sbq[0].at <= cyc) begin
          nvec++;
          nfail++;
          e = sbq.pop_front();
          $display("FAIL missing_out cyc=%0d got out_valid=0, required a=%0d b=%0d", cyc, e.a, e.b);
        end
      end
    end
  end

  task automatic drive(input bit vld, input int uu, input int vv, input int ww,
                       input bit md, input bit tw, input bit hf);
    @(posedge clk);
    #1;
    in_valid = vld;
    u        = 12'(uu);
    v        = 12'(vv);
    w        = 12'(ww);
    mode     = md;
    tw_sel   = tw;
    half     = hf;
  endtask

  task automatic send(input int uu, input int vv, input int ww, input bit md,
                      input bit tw, input bit hf, input int ea, input int eb);
    exp_t x;
    drive(1'b1, uu, vv, ww, md, tw, hf);
    x.a  = ea;
    x.b  = eb;
    x.at = cyc + LAT;
    sbq.push_back(x);
  endtask

  function automatic int hlv(input int x);
    return (x % 2 == 0) ? x / 2 : (x + QM) / 2;
  endfunction

  task automatic sendm(input int uu, input int vv, input int ww, input bit md,
                       input bit tw, input bit hf);
    int t, vt, ea, eb;
    t = tw ? ww : TWC;
    if (!md) begin
      vt = (vv * t) % QM;
      ea = (uu + vt) % QM;
      eb = (uu - vt + QM) % QM;
    end else begin
      ea = (uu + vv) % QM;
      eb = (((uu - vv + QM) % QM) * t) % QM;
      if (hf) begin
        ea = hlv(ea);
        eb = hlv(eb);
      end
    end
    send(uu, vv, ww, md, tw, hf, ea, eb);
  endtask

  function automatic int rop();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return 0;
    if (r == 1) return QM - 1;
    return int'($urandom_range(0, QM - 1));
  endfunction

  task automatic idle(input int n);
    repeat (n) drive(1'b0, rop(), rop(), rop(), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
  endtask

  task automatic send_rand(input bit md);
    sendm(rop(), rop(), rop(), md, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic check_reset_state(input string tag);
    nvec++;
    if (out_valid !== 1'b0 || bf_a !== 12'd0 || bf_b !== 12'd0) begin
      nfail++;
      $display("FAIL %s valid=%b a=%0d b=%0d, required valid=0 a=0 b=0", tag, out_valid, bf_a, bf_b);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset_state");
    mon_en = 1'b1;

    send(5, 3, 7, 1'b0, 1'b1, 1'b0, 26, 3313);
    idle(LAT + 2);
    send(3328, 1, 1, 1'b0, 1'b1, 1'b0, 0, 3327);
    send(0, 1, 0, 1'b0, 1'b0, 1'b0, 2285, 1044);
    send(10, 4, 3, 1'b1, 1'b1, 1'b0, 14, 18);
    send(10, 4, 3, 1'b1, 1'b1, 1'b1, 7, 9);
    send(4, 1, 1, 1'b1, 1'b1, 1'b1, 1667, 1666);
    send(100, 100, 5, 1'b1, 1'b1, 1'b0, 200, 0);
    send(7, 0, 9, 1'b0, 1'b1, 1'b0, 7, 7);
    send(7, 9, 0, 1'b0, 1'b1, 1'b0, 7, 7);
    send(3000, 1000, 1, 1'b1, 1'b1, 1'b0, 671, 2000);
    send(3, 5, 1, 1'b0, 1'b1, 1'b1, 8, 3327);
    idle(LAT + 2);

    for (int i = 0; i < 16; i++) send_rand(1'(i % 2));
    idle(LAT + 2);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      else send_rand(1'($urandom_range(0, 1)));
    end
    idle(LAT + 2);

    for (int i = 0; i < 3; i++) send_rand(1'(i % 2));
    drive(1'b1, 11, 22, 33, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    last_a = 0;
    last_b = 0;
    check_reset_state("reset_midstream");
    idle(1);
    send(5, 3, 7, 1'b0, 1'b1, 1'b0, 26, 3313);
    idle(LAT + 2);

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) idle(1);
      else send_rand(1'($urandom_range(0, 1)));
    end
    idle(LAT + 4);

    nvec++;
    if (sbq.size() != 0) begin
      nfail++;
      $display("FAIL drain pending=%0d, required 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
